keypad_matrix_scan: RTL and testbench

Scans a 4×4 active-low matrix keypad, debounces the result and produces the `IsPressed` / `keyboard_data` pair consumed by the LED display stage. It sits between the keypad pins and the display/LCD logic, and is the only block that touches the keypad rows and columns. Output codes are 0x0–0xF. Outputs are held stable between debounced commits.

---
 rtl/keypad_matrix_scan.sv | 152 +++++++++++++++
 tb/tb_keypad_matrix_scan.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner: column drive, row synchronizer, per-frame
// lowest-code capture and frame-count debounce feeding the display stage.
module keypad_matrix_scan #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       IsPressed,
    output logic [3:0] keyboard_data,
    output logic       key_valid
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] COL0 = 2'd0;
    localparam logic [1:0] COL1 = 2'd1;
    localparam logic [1:0] COL2 = 2'd2;
    localparam logic [1:0] COL3 = 2'd3;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [DIV_W-1:0] div;
    logic             sample;

    logic [3:0]       row_m;
    logic [3:0]       row_s;

    logic             hit_now;
    logic [1:0]       hit_row;
    logic [3:0]       code_now;
    logic             acc_pressed;
    logic [3:0]       acc_code;
    logic             merged_pressed;
    logic [3:0]       merged_code;

    logic             f_pressed;
    logic [3:0]       f_code;
    logic             frame_done;

    logic             prev_pressed;
    logic [3:0]       prev_code;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             commit;

    // Column state register
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= COL0;
        else            state_q <= state_d;
    end

    // Advance one column at each sample point
    always_comb begin
        state_d = state_q;
        sample  = (div == DIV_W'(SCAN_DIV - 1));
        if (sample) begin
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                COL2:    state_d = COL3;
                default: state_d = COL0;
            endcase
        end
    end

    // Lowest row hit in the current column, merged with the frame so far
    always_comb begin
        hit_now = 1'b0;
        hit_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s[r]) begin
                hit_now = 1'b1;
                hit_row = 2'(r);
            end
        end
        code_now       = {hit_row, state_q};
        merged_pressed = acc_pressed | hit_now;
        merged_code    = acc_code;
        if (hit_now && (!acc_pressed || (code_now < acc_code))) merged_code = code_now;
    end

    // Debounce counter update and commit decision
    always_comb begin
        if ({f_pressed, f_code} == {prev_pressed, prev_code}) begin
            if (stable_cnt >= CNT_W'(DEBOUNCE_FRAMES)) cnt_nxt = CNT_W'(DEBOUNCE_FRAMES);
            else                                        cnt_nxt = stable_cnt + CNT_W'(1);
        end else begin
            cnt_nxt = CNT_W'(1);
        end
        commit = frame_done && (cnt_nxt == CNT_W'(DEBOUNCE_FRAMES));
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div           <= '0;
            row_m         <= 4'hF;
            row_s         <= 4'hF;
            col           <= 4'b1110;
            acc_pressed   <= 1'b0;
            acc_code      <= 4'h0;
            f_pressed     <= 1'b0;
            f_code        <= 4'h0;
            frame_done    <= 1'b0;
            prev_pressed  <= 1'b0;
            prev_code     <= 4'h0;
            stable_cnt    <= '0;
            IsPressed     <= 1'b0;
            keyboard_data <= 4'h0;
            key_valid     <= 1'b0;
        end else begin
            div        <= sample ? '0 : div + DIV_W'(1);
            row_m      <= row;
            row_s      <= row_m;
            col        <= ~(4'b0001 << state_d);
            frame_done <= 1'b0;
            key_valid  <= 1'b0;

            if (sample) begin
                if (state_q == COL3) begin
                    f_pressed   <= merged_pressed;
                    f_code      <= merged_code;
                    frame_done  <= 1'b1;
                    acc_pressed <= 1'b0;
                    acc_code    <= 4'h0;
                end else begin
                    acc_pressed <= merged_pressed;
                    acc_code    <= merged_code;
                end
            end

            if (frame_done) begin
                prev_pressed <= f_pressed;
                prev_code    <= f_code;
                stable_cnt   <= cnt_nxt;
            end

            // Re-commits of an unchanged value leave outputs untouched
            if (commit) begin
                IsPressed <= f_pressed;
                if (f_pressed) begin
                    keyboard_data <= f_code;
                    key_valid     <= !IsPressed || (keyboard_data != f_code);
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Bench for keypad_matrix_scan: keypad pin model, frame-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_keypad_matrix_scan;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int          FRAME    = 16;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        IsPressed;
    logic [3:0]  keyboard_data;
    logic        key_valid;

    logic [15:0] keys = 16'h0000;

    int checks = 0;
    int errors = 0;
    int kv_count = 0;

    keypad_matrix_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .row          (row),
        .col          (col),
        .IsPressed    (IsPressed),
        .keyboard_data(keyboard_data),
        .key_valid    (key_valid)
    );

    initial forever #5 clk = ~clk;

    // Physical keypad: a held key ties its row to a low column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles since reset, key history, frame results
    int          cyc = 0;
    logic [15:0] hist [64];
    int          run = 0;
    int          prev_p = 0;
    int          prev_c = 0;
    int          pend = 0;
    int          pend_p = 0;
    int          pend_c = 0;
    int          exp_ip = 0;
    int          exp_kd = 0;
    int          exp_kv = 0;

    initial forever begin
        @(posedge clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
            cyc = 0; run = 0; prev_p = 0; prev_c = 0; pend = 0;
            exp_ip = 0; exp_kd = 0; exp_kv = 0;
        end else begin
            int fp;
            int fc;
            cyc++;
            hist[cyc % 64] = keys;
            exp_kv = 0;
            if (pend != 0) begin
                if (pend_p != 0) begin
                    if (exp_ip == 0 || exp_kd != pend_c) exp_kv = 1;
                    exp_kd = pend_c;
                end
                exp_ip = pend_p;
                pend = 0;
            end
            if (cyc % FRAME == 0) begin
                // column c is sampled 2 cycles after the keys seen at cyc-14+4c
                fp = 0;
                fc = 0;
                for (int k = 0; k < 16; k++) begin
                    int c;
                    logic [15:0] h;
                    c = k % 4;
                    h = hist[(cyc - 14 + 4*c) % 64];
                    if (fp == 0 && h[k]) begin
                        fp = 1;
                        fc = k;
                    end
                end
                if (fp == prev_p && fc == prev_c) run = (run < DEB) ? run + 1 : DEB;
                else                              run = 1;
                prev_p = fp;
                prev_c = fc;
                if (run == DEB) begin
                    pend = 1; pend_p = fp; pend_c = fc;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("col", int'(col), 15 ^ (1 << ((cyc / 4) % 4)));
        chk("IsPressed", int'(IsPressed), exp_ip);
        chk("keyboard_data", int'(keyboard_data), exp_kd);
        chk("key_valid", int'(key_valid), exp_kv);
        if (key_valid) kv_count++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        chk("reset_col", int'(col), 4'hE);
        chk("reset_IsPressed", int'(IsPressed), 0);
        chk("reset_keyboard_data", int'(keyboard_data), 0);
        chk("reset_key_valid", int'(key_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int kv0;
        #2;
        // 1: reset and idle scan
        do_reset();
        wait_cyc(10 * FRAME);
        chk("idle_IsPressed", int'(IsPressed), 0);
        chk("idle_keyboard_data", int'(keyboard_data), 0);
        chk("idle_kv_count", kv_count, 0);

        // 2: clean press of 0x9 then release
        kv0 = kv_count;
        keys = 16'h0200;
        wait_cyc(6 * FRAME);
        chk("press9_IsPressed", int'(IsPressed), 1);
        chk("press9_keyboard_data", int'(keyboard_data), 9);
        chk("press9_pulses", kv_count - kv0, 1);
        keys = 16'h0000;
        wait_cyc(5 * FRAME);
        chk("release9_IsPressed", int'(IsPressed), 0);
        chk("release9_keyboard_data", int'(keyboard_data), 9);

        // 3: bounce on 0x3, then hold
        kv0 = kv_count;
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 1) ? 16'h0008 : 16'h0000;
            wait_cyc(FRAME);
        end
        chk("bounce_no_commit", int'(IsPressed), 0);
        chk("bounce_no_pulse", kv_count - kv0, 0);
        keys = 16'h0008;
        wait_cyc(5 * FRAME);
        chk("bounce_hold_keyboard_data", int'(keyboard_data), 3);
        chk("bounce_hold_pulses", kv_count - kv0, 1);
        keys = 16'h0000;
        wait_cyc(5 * FRAME);

        // 4: multi-key 0xE + 0x5, then drop 0x5
        kv0 = kv_count;
        keys = 16'h4020;
        wait_cyc(6 * FRAME);
        chk("multi_keyboard_data", int'(keyboard_data), 5);
        chk("multi_pulses", kv_count - kv0, 1);
        keys = 16'h4000;
        wait_cyc(6 * FRAME);
        chk("multi_remaining_keyboard_data", int'(keyboard_data), 14);
        chk("multi_remaining_IsPressed", int'(IsPressed), 1);
        chk("multi_remaining_pulses", kv_count - kv0, 2);
        keys = 16'h0000;
        wait_cyc(5 * FRAME);

        // 5: reset while in COL2 with 0xA committed
        keys = 16'h0400;
        wait_cyc(6 * FRAME);
        chk("preRst_keyboard_data", int'(keyboard_data), 10);
        for (int i = 0; i < 20 && col != 4'b1011; i++) wait_cyc(1);
        chk("col2_reached", int'(col), 4'b1011);
        do_reset();
        kv0 = kv_count;
        wait_cyc(6 * FRAME);
        chk("postRst_keyboard_data", int'(keyboard_data), 10);
        chk("postRst_IsPressed", int'(IsPressed), 1);
        chk("postRst_pulses", kv_count - kv0, 1);
        keys = 16'h0000;
        wait_cyc(5 * FRAME);

        // 6: every key in turn
        for (int k = 0; k < 16; k++) begin
            kv0 = kv_count;
            keys = 16'(1 << k);
            wait_cyc(5 * FRAME);
            chk("allkeys_keyboard_data", int'(keyboard_data), k);
            chk("allkeys_IsPressed", int'(IsPressed), 1);
            chk("allkeys_pulses", kv_count - kv0, 1);
            keys = 16'h0000;
            wait_cyc(5 * FRAME);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
